// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the MIPS32 pipeline sequencing controller.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } ctrl_state_t;

    localparam logic [4:0]  REG_ZERO       = 5'd0;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0000;
    localparam int          MD_LATENCY_DEF = 8;

endpackage

// File: rtl/pipe_hazard_ctrl_md_latency_counter.sv
// Mul/div occupancy down-counter: loadable, decrements on request, flags zero.
module md_latency_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_val;
        else if (dec)
            cnt_d = cnt_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/bubble/hold sequencing for load-use, EX-resolved jumps and mul/div.
// Define MD_UNIT_EN to build the multi-cycle mul/div occupancy tracking.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MD_LATENCY = MD_LATENCY_DEF,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_valid,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             jump_cs,
    input  logic             md_start,
    output logic             stall,
    output logic             flush_ifid,
    output logic             bubble_idex,
    output logic             hold_ex,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cycles
);

    logic             lu;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    assign lu = ex_valid & ex_mem_read & id_valid & (ex_rt != REG_ZERO) &
                ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

`ifdef MD_UNIT_EN
    localparam int MD_W = $clog2(MD_LATENCY);

    ctrl_state_t state_q, state_d;
    logic        md_busy_q, md_busy_d;
    logic        md_load, md_zero;

    md_latency_counter #(.W(MD_W)) u_md_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (md_load),
        .load_val (MD_W'(MD_LATENCY - 1)),
        .dec      (state_q == MD_BUSY),
        .zero     (md_zero)
    );

    always_comb begin
        state_d     = state_q;
        md_load     = 1'b0;
        stall       = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        hold_ex     = 1'b0;
        md_done     = 1'b0;
        if (!rst) begin
            case (state_q)
                RUN: begin
                    if (jump_cs) begin
                        flush_ifid  = 1'b1;
                        bubble_idex = 1'b1;
                    end else if (lu) begin
                        stall       = 1'b1;
                        bubble_idex = 1'b1;
                    end else if (md_start) begin
                        md_load = 1'b1;
                        state_d = MD_BUSY;
                    end
                end
                MD_BUSY: begin
                    // A jump here cannot happen: EX is frozen holding the mul/div.
                    if (md_zero) begin
                        md_done = 1'b1;
                        state_d = RUN;
                    end else begin
                        stall   = 1'b1;
                        hold_ex = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
        md_busy_d = (state_d == MD_BUSY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            md_busy_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            md_busy_q <= md_busy_d;
        end
    end

    assign md_busy = md_busy_q;

    a_no_jump_in_md_busy: assert property (@(posedge clk) disable iff (rst)
        (state_q == MD_BUSY) |-> !jump_cs);
`else
    localparam int md_lat_unused = MD_LATENCY;
    logic md_start_unused;
    assign md_start_unused = md_start;

    always_comb begin
        stall       = 1'b0;
        flush_ifid  = 1'b0;
        bubble_idex = 1'b0;
        if (!rst) begin
            if (jump_cs) begin
                flush_ifid  = 1'b1;
                bubble_idex = 1'b1;
            end else if (lu) begin
                stall       = 1'b1;
                bubble_idex = 1'b1;
            end
        end
    end

    assign hold_ex = 1'b0;
    assign md_busy = 1'b0;
    assign md_done = 1'b0;
`endif

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && !(&stall_cycles_q))
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cycles_q <= '0;
        else
            stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench: directed vector table, hand sequences, and random stimulus vs. a reference model.
module tb_pipe_hazard_ctrl;

    localparam int LAT  = 8;
    localparam int CW   = 6;
    localparam int CMAX = (1 << CW) - 1;
`ifdef MD_UNIT_EN
    localparam bit MD_EN = 1'b1;
`else
    localparam bit MD_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid, id_uses_rs, id_uses_rt;
    logic [4:0]    id_rs, id_rt, ex_rt;
    logic          ex_valid, ex_mem_read, jump_cs, md_start;
    logic          stall, flush_ifid, bubble_idex, hold_ex, md_busy, md_done;
    logic [CW-1:0] stall_cycles;

    int errors = 0;
    int checks = 0;

    // Reference model: remaining mul/div cycles (including the done cycle) and stall total.
    int m_left;
    int m_cnt;

    // Last observed outputs, for explicit per-cycle checks.
    logic o_stall, o_flush, o_bubble, o_hold, o_busy, o_done;
    int   o_cnt;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .ex_valid     (ex_valid),
        .ex_mem_read  (ex_mem_read),
        .ex_rt        (ex_rt),
        .jump_cs      (jump_cs),
        .md_start     (md_start),
        .stall        (stall),
        .flush_ifid   (flush_ifid),
        .bubble_idex  (bubble_idex),
        .hold_ex      (hold_ex),
        .md_busy      (md_busy),
        .md_done      (md_done),
        .stall_cycles (stall_cycles)
    );

    typedef struct {
        logic       r, iv;
        logic [4:0] rs, rt;
        logic       urs, urt, ev, mr;
        logic [4:0] ert;
        logic       j;
        logic       es, ef, eb;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit lu_now();
        bit hit_rs, hit_rt;
        hit_rs = id_uses_rs && (id_rs == ex_rt);
        hit_rt = id_uses_rt && (id_rt == ex_rt);
        return ex_valid && ex_mem_read && id_valid && (ex_rt != 5'd0) && (hit_rs || hit_rt);
    endfunction

    task automatic model_out(output bit s, output bit f, output bit b, output bit h, output bit d);
        s = 0; f = 0; b = 0; h = 0; d = 0;
        if (!rst) begin
            if (m_left > 0) begin
                if (m_left == 1) d = 1;
                else begin s = 1; h = 1; end
            end else if (jump_cs) begin
                f = 1; b = 1;
            end else if (lu_now()) begin
                s = 1; b = 1;
            end
        end
    endtask

    task automatic model_step(input bit s);
        if (rst) begin
            m_left = 0;
            m_cnt  = 0;
        end else begin
            if (s && m_cnt < CMAX) m_cnt++;
            if (m_left > 0) m_left--;
            else if (MD_EN && !jump_cs && !lu_now() && md_start) m_left = LAT;
        end
    endtask

    task automatic cyc(input bit tv = 0, input bit es = 0, input bit ef = 0, input bit eb = 0);
        bit s, f, b, h, d;
        @(negedge clk);
        model_out(s, f, b, h, d);
        o_stall = stall; o_flush = flush_ifid; o_bubble = bubble_idex;
        o_hold = hold_ex; o_busy = md_busy; o_done = md_done; o_cnt = int'(stall_cycles);
        chk("stall", 32'(stall), 32'(s));
        chk("flush_ifid", 32'(flush_ifid), 32'(f));
        chk("bubble_idex", 32'(bubble_idex), 32'(b));
        chk("hold_ex", 32'(hold_ex), 32'(h));
        chk("md_done", 32'(md_done), 32'(d));
        chk("md_busy", 32'(md_busy), 32'(m_left > 0));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        if (tv) begin
            chk("tbl_stall", 32'(stall), 32'(es));
            chk("tbl_flush", 32'(flush_ifid), 32'(ef));
            chk("tbl_bubble", 32'(bubble_idex), 32'(eb));
        end
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0;
        ex_valid = 0; ex_mem_read = 0; ex_rt = 0; jump_cs = 0; md_start = 0;
    endtask

    task automatic set_lu(input logic [4:0] r);
        id_valid = 1; id_rs = r; id_uses_rs = 1; id_uses_rt = 0;
        ex_valid = 1; ex_mem_read = 1; ex_rt = r;
    endtask

    initial begin
        vec_t tbl[11];
        tbl[0]  = '{1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{1'b0, 1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[2]  = '{1'b0, 1'b1, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0, 1'b1};

        // Initial reset without checks: DUT state is unknown until the first edge.
        idle();
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        m_left = 0; m_cnt = 0;
        rst = 0;

        cyc();
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_cnt", 32'(o_cnt), 32'd0);

        for (int i = 0; i < 11; i++) begin
            rst = tbl[i].r; id_valid = tbl[i].iv; id_rs = tbl[i].rs; id_rt = tbl[i].rt;
            id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt; ex_valid = tbl[i].ev;
            ex_mem_read = tbl[i].mr; ex_rt = tbl[i].ert; jump_cs = tbl[i].j; md_start = 0;
            cyc(1'b1, tbl[i].es, tbl[i].ef, tbl[i].eb);
        end

        // Load-use: one stall, then a second dependent load gets its own stall.
        idle(); rst = 1; cyc(); rst = 0;
        set_lu(5'd5); cyc();
        chk("lu_stall", 32'(o_stall), 32'd1);
        chk("lu_bubble", 32'(o_bubble), 32'd1);
        ex_valid = 0; cyc();
        chk("lu_after_stall", 32'(o_stall), 32'd0);
        chk("lu_cnt", 32'(o_cnt), 32'd1);
        set_lu(5'd6); cyc();
        chk("lu2_stall", 32'(o_stall), 32'd1);
        ex_valid = 0; cyc();
        chk("lu2_after_stall", 32'(o_stall), 32'd0);
        chk("lu2_cnt", 32'(o_cnt), 32'd2);

`ifdef MD_UNIT_EN
        idle(); rst = 1; cyc(); rst = 0;
        md_start = 1; cyc(); md_start = 0;
        for (int k = 1; k <= LAT; k++) begin
            cyc();
            chk("md_busy_win", 32'(o_busy), 32'd1);
            chk("md_stall_win", 32'(o_stall), 32'(k < LAT));
            chk("md_hold_win", 32'(o_hold), 32'(k < LAT));
            chk("md_done_win", 32'(o_done), 32'(k == LAT));
        end
        cyc();
        chk("md_busy_end", 32'(o_busy), 32'd0);
        chk("md_cnt", 32'(o_cnt), 32'd7);

        // Back-to-back: md_start held through the done cycle is taken one cycle later.
        md_start = 1; cyc();
        for (int k = 1; k <= LAT; k++) cyc();
        chk("b2b_done", 32'(o_done), 32'd1);
        cyc();
        chk("b2b_gap_busy", 32'(o_busy), 32'd0);
        md_start = 0; cyc();
        chk("b2b_second_busy", 32'(o_busy), 32'd1);
        for (int k = 1; k < LAT; k++) cyc();

        // Reset mid-operation: no md_done afterwards.
        idle(); rst = 1; cyc(); rst = 0;
        md_start = 1; cyc(); md_start = 0;
        cyc(); cyc();
        rst = 1; cyc();
        chk("rst_mid_stall", 32'(o_stall), 32'd0);
        chk("rst_mid_hold", 32'(o_hold), 32'd0);
        rst = 0; cyc();
        chk("rst_mid_busy", 32'(o_busy), 32'd0);
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("rst_mid_no_done", 32'(o_done), 32'd0);
        end
`else
        idle(); md_start = 1;
        for (int k = 0; k < 12; k++) begin
            cyc();
            chk("nomd_busy", 32'(o_busy), 32'd0);
            chk("nomd_done", 32'(o_done), 32'd0);
            chk("nomd_hold", 32'(o_hold), 32'd0);
            chk("nomd_stall", 32'(o_stall), 32'd0);
        end
`endif

        // Counter saturation.
        idle(); rst = 1; cyc(); rst = 0;
        set_lu(5'd3);
        for (int k = 0; k < CMAX + 8; k++) cyc();
        chk("cnt_saturate", 32'(o_cnt), 32'(CMAX));

        // Random stimulus against the model.
        idle(); rst = 1; cyc(); rst = 0;
        for (int n = 0; n < 3000; n++) begin
            rst         = ($urandom_range(63) == 0);
            id_valid    = ($urandom_range(3) != 0);
            id_rs       = 5'($urandom_range(3));
            id_rt       = 5'($urandom_range(3));
            id_uses_rs  = 1'($urandom_range(1));
            id_uses_rt  = 1'($urandom_range(1));
            ex_valid    = ($urandom_range(3) != 0);
            ex_mem_read = 1'($urandom_range(1));
            ex_rt       = 5'($urandom_range(3));
            jump_cs     = (m_left == 0) && ($urandom_range(7) == 0);
            md_start    = ($urandom_range(5) == 0);
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
